// File: rtl/alu_fetch_if.sv
// ---------------------------------------------------------------------------
// alu_fetch_if
// Interface bundle between the sequencer, the neighbour ports, the
// alu_fetch stage, and the downstream registers block.
//   op_valid/op_ready/op/src/imm : decoded-instruction handshake
//   acc                          : current ACC value from registers
//   in_valid/in_data/in_ack      : four neighbour ports (UP, DOWN, LEFT, RIGHT)
//   reg_en/reg_instr/reg_val     : single-beat command to registers
//   blocked                      : stage is waiting on a port read
// master = driver side (sequencer/ports), slave = alu_fetch.
// ---------------------------------------------------------------------------
interface alu_fetch_if;
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op;
    logic [3:0]         src;
    logic signed [10:0] imm;
    logic signed [10:0] acc;
    logic [3:0]         in_valid;
    logic [43:0]        in_data;
    logic [3:0]         in_ack;
    logic               reg_en;
    logic [1:0]         reg_instr;
    logic signed [10:0] reg_val;
    logic               blocked;

    modport master (
        output op_valid, op, src, imm, acc, in_valid, in_data,
        input  op_ready, in_ack, reg_en, reg_instr, reg_val, blocked
    );

    modport slave (
        input  op_valid, op, src, imm, acc, in_valid, in_data,
        output op_ready, in_ack, reg_en, reg_instr, reg_val, blocked
    );
endinterface

// File: rtl/alu_fetch.sv
// ---------------------------------------------------------------------------
// alu_fetch
// Operand-fetch and saturating arithmetic stage of a TIS-100 node. Accepts
// one decoded instruction, resolves its source operand (IMM/ACC/NIL/port/
// ANY/LAST), stalls while a port read has no data, and issues a single
// command beat to the registers block.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_fetch_if.slave (instruction handshake, ports, register cmd)
// Parameter:
//   SAT_MAX : saturation bound, results clamp to [-SAT_MAX, SAT_MAX]
// ---------------------------------------------------------------------------
module alu_fetch #(
    parameter int SAT_MAX = 999
) (
    input  logic        clk,
    input  logic        reset,
    alu_fetch_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;

    localparam logic signed [11:0] PMAX = 12'(SAT_MAX);
    localparam logic signed [11:0] NMAX = -PMAX;

    // op encodings
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;
    localparam logic [2:0] OP_SAV = 3'd5;
    localparam logic [2:0] OP_SWP = 3'd6;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [3:0]         src_q;
    logic signed [10:0] imm_q;
    logic [1:0]         last_q;
    logic               last_set_q;

    logic               op_ready_q;
    logic               reg_en_q;
    logic [1:0]         reg_instr_q;
    logic signed [10:0] reg_val_q;
    logic [3:0]         in_ack_q;

    logic               use_port;
    logic [1:0]         port_sel;
    logic signed [10:0] opnd;
    logic               avail;
    logic               need;
    logic               go;
    logic signed [11:0] sum;
    logic signed [11:0] diff;
    logic signed [11:0] neg;
    logic [1:0]         instr_d;
    logic signed [10:0] val_d;
    logic [3:0]         ack_d;

    function automatic logic signed [10:0] sat(input logic signed [11:0] v);
        if (v > PMAX)      return PMAX[10:0];
        else if (v < NMAX) return NMAX[10:0];
        else               return v[10:0];
    endfunction

    // Operand resolution for the latched instruction.
    always_comb begin
        use_port = 1'b0;
        port_sel = 2'd0;
        opnd     = '0;
        case (src_q)
            4'd0: opnd = sat({imm_q[10], imm_q});
            4'd1: opnd = bus.acc;
            4'd3, 4'd4, 4'd5, 4'd6: begin
                use_port = 1'b1;
                port_sel = 2'(src_q - 4'd3);
            end
            4'd7: begin
                // ANY: LEFT, RIGHT, UP, DOWN priority. With nothing valid the
                // pick is irrelevant, it just leaves avail low.
                use_port = 1'b1;
                if (bus.in_valid[2])      port_sel = 2'd2;
                else if (bus.in_valid[3]) port_sel = 2'd3;
                else if (bus.in_valid[0]) port_sel = 2'd0;
                else if (bus.in_valid[1]) port_sel = 2'd1;
                else                      port_sel = 2'd2;
            end
            4'd8: begin
                if (last_set_q) begin
                    use_port = 1'b1;
                    port_sel = last_q;
                end
            end
            default: ; // NIL and unused codes
        endcase
        if (use_port)
            opnd = bus.in_data[11*port_sel +: 11];
        avail = !use_port || bus.in_valid[port_sel];
    end

    // Result computation; 12-bit intermediates cannot overflow from 11-bit inputs.
    always_comb begin
        need    = (op_q == OP_MOV) || (op_q == OP_ADD) || (op_q == OP_SUB);
        sum     = {bus.acc[10], bus.acc} + {opnd[10], opnd};
        diff    = {bus.acc[10], bus.acc} - {opnd[10], opnd};
        neg     = 12'sd0 - {bus.acc[10], bus.acc};
        instr_d = 2'b00;
        val_d   = reg_val_q;
        case (op_q)
            OP_MOV: begin instr_d = 2'b01; val_d = opnd;      end
            OP_ADD: begin instr_d = 2'b01; val_d = sat(sum);  end
            OP_SUB: begin instr_d = 2'b01; val_d = sat(diff); end
            OP_NEG: begin instr_d = 2'b01; val_d = sat(neg);  end
            OP_SAV: instr_d = 2'b10;
            OP_SWP: instr_d = 2'b11;
            default: ;
        endcase
        go    = (state_q == S_FETCH) && (!need || avail);
        ack_d = (need && use_port) ? (4'b0001 << port_sel) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            src_q       <= '0;
            imm_q       <= '0;
            last_q      <= 2'd0;   // UP
            last_set_q  <= 1'b0;
            op_ready_q  <= 1'b1;
            reg_en_q    <= 1'b0;
            reg_instr_q <= 2'b00;
            reg_val_q   <= '0;
            in_ack_q    <= 4'b0000;
        end else begin
            reg_en_q <= 1'b0;
            in_ack_q <= 4'b0000;
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_q       <= bus.op;
                        src_q      <= bus.src;
                        imm_q      <= bus.imm;
                        op_ready_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (go) begin
                        reg_en_q    <= 1'b1;
                        reg_instr_q <= instr_d;
                        reg_val_q   <= val_d;
                        in_ack_q    <= ack_d;
                        if (need && src_q == 4'd7) begin
                            last_q     <= port_sel;
                            last_set_q <= 1'b1;
                        end
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    reg_instr_q <= 2'b00;
                    op_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.reg_en    = reg_en_q;
    assign bus.reg_instr = reg_instr_q;
    assign bus.reg_val   = reg_val_q;
    assign bus.in_ack    = in_ack_q;
    assign bus.blocked   = (state_q == S_FETCH) && need && !avail;

endmodule

// File: doc/alu_fetch.md
# alu_fetch

Operand-fetch and arithmetic stage sitting directly upstream of `registers` in a TIS-100 node. Accepts one decoded instruction at a time from the sequencer, obtains its source operand (immediate, ACC, NIL, or a blocking read from one of four neighbour ports), computes the saturated result, and issues a single `instr`/`input_val`/`clk_en` beat to `registers`. It stalls on port reads until a neighbour presents data.

## Interface
- `SAT_MAX`, default 999: positive saturation bound; the negative bound is `-SAT_MAX`.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  decoded instruction present.
- `op_ready`  out  1  block can accept an instruction.
- `op`  in  3  0 NOP, 1 MOV-to-ACC, 2 ADD, 3 SUB, 4 NEG, 5 SAV, 6 SWP, 7 treated as NOP.
- `src`  in  4  0 IMM, 1 ACC, 2 NIL, 3 UP, 4 DOWN, 5 LEFT, 6 RIGHT, 7 ANY, 8 LAST; 9–15 treated as NIL.
- `imm`  in  11  signed immediate.
- `acc`  in  11  signed ACC value from `registers` output.
- `in_valid`  in  4  per-port data valid; bit 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- `in_data`  in  44  port data; port i on bits [11i+10:11i].
- `in_ack`  out  4  one-cycle consume pulse per port.
- `reg_en`  out  1  one-cycle strobe, drives `registers` `clk_en`.
- `reg_instr`  out  2  00 hold, 01 load ACC from `reg_val`, 10 SAV, 11 SWP.
- `reg_val`  out  11  signed value for load.
- `blocked`  out  1  high while waiting on a port read.

## Operation
- FSM states: IDLE, FETCH, ISSUE.
  - IDLE: `op_ready`=1. When `op_valid` is high, latch `op`/`src`/`imm` and go to FETCH.
  - FETCH: evaluate the operand. If available, register the results and go to ISSUE. Otherwise stay in FETCH with `blocked`=1.
  - ISSUE: `reg_en`=1 for exactly one cycle, then go to IDLE.
- Operand needed only for MOV/ADD/SUB. NOP/NEG/SAV/SWP never read ports and never block.
- Operand sources:
  - IMM: `imm` clamped to [-SAT_MAX, SAT_MAX].
  - ACC: `acc`.
  - NIL: 0.
  - Named port p: available when `in_valid[p]`=1; value `in_data` slice p.
  - ANY: first valid port in priority LEFT, RIGHT, UP, DOWN. The chosen port is recorded as LAST and `last_set` is set.
  - LAST: recorded port if `last_set`, else behaves as NIL, never blocks.
- Results:
  - MOV: `reg_instr`=01, `reg_val`=operand.
  - ADD/SUB: 12-bit signed `acc`±operand, clamped to ±SAT_MAX, `reg_instr`=01.
  - NEG: `reg_val`=-`acc` (clamped), `reg_instr`=01.
  - SAV: 10. SWP: 11. NOP: 00.
- `in_ack[p]` pulses in the ISSUE cycle for the port consumed. At most one bit is set.

## Timing
- Reset (async assert, sync-safe release) sets:
  - state IDLE, `op_ready`=1.
  - `reg_en`=0, `reg_instr`=00, `reg_val`=0.
  - `in_ack`=0, `blocked`=0.
  - `last_set`=0, LAST=UP.
- Reset mid-operation abandons the instruction with no `reg_en` and no `in_ack`.
- Non-blocking instruction accepted at edge E0: FETCH during E0→E1, ISSUE during E1→E2 (`registers` updates ACC/BAK at E2), `op_ready` high again after E2. Throughput is one op per 3 cycles.
- Each extra port-wait cycle adds one cycle. `blocked` is high in every FETCH cycle where the operand is unavailable.
- `acc` is sampled in the FETCH cycle that completes. It is stable because no write is outstanding.
- Port data is sampled in the same FETCH cycle that sees `in_valid`. The sender must hold data until `in_ack`.
- `op_valid` is ignored outside IDLE.

## Test plan
- After reset: `op`=MOV, `src`=IMM, `imm`=5 → `reg_en` pulse 2 cycles after accept with `reg_instr`=01, `reg_val`=5; `op_ready` returns after 3 cycles.
- `acc`=990, ADD IMM 20 → `reg_val`=999. `acc`=-990, SUB IMM 20 → -999. `imm`=1023 (MOV) → 999.
- MOV from LEFT with `in_valid`=0 for 4 cycles → `blocked`=1 for 4 cycles. Then LEFT data=-7 → `reg_val`=-7, `in_ack`=0100 for one cycle.
- ANY with UP and RIGHT both valid (UP=3, RIGHT=8) → value 8 taken, `in_ack`=1000. A following MOV LAST with RIGHT=11 → 11.
- MOV LAST directly after reset → `reg_val`=0, no block. SAV → `reg_instr`=10. SWP → 11. NEG with `acc`=-999 → 999.
- Reset asserted while blocked in FETCH → outputs return to reset values immediately; no `in_ack` or `reg_en` afterwards until a new op is accepted.
